// File: rtl/traffic_pkg.sv
// Shared lamp codes, controller state set and lamp decode for the intersection controller.
package traffic_pkg;

  localparam logic [2:0] RED   = 3'b101;
  localparam logic [2:0] GREEN = 3'b110;
  localparam logic [2:0] AMBER = 3'b011;

  typedef enum logic [2:0] {
    NS_GREEN   = 3'd0,
    NS_AMBER   = 3'd1,
    ALLRED_A   = 3'd2,
    EW_GREEN   = 3'd3,
    EW_AMBER   = 3'd4,
    ALLRED_B   = 3'd5,
    PED_WALK   = 3'd6,
    EMERG_HOLD = 3'd7
  } ctrlState;

  function automatic logic [2:0] nsLamp(input ctrlState s);
    case (s)
      NS_GREEN: nsLamp = GREEN;
      NS_AMBER: nsLamp = AMBER;
      default:  nsLamp = RED;
    endcase
  endfunction

  function automatic logic [2:0] ewLamp(input ctrlState s);
    case (s)
      EW_GREEN: ewLamp = GREEN;
      EW_AMBER: ewLamp = AMBER;
      default:  ewLamp = RED;
    endcase
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Loadable down-counter that parks at zero; zero flags the last cycle of a timed phase.
module phase_timer #(
  parameter int unsigned WIDTH = 3,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] loadValue,
  output logic [WIDTH-1:0] value,
  output logic             zero
);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      value <= RESET_VAL;
    else if (load)
      value <= loadValue;
    else if (value != '0)
      value <= value - 1'b1;
  end

  assign zero = (value == '0);

endmodule

// File: rtl/intersection_controller.sv
// Two-road traffic light controller with pedestrian walk phase and emergency all-red hold.
module intersection_controller
  import traffic_pkg::*;
#(
  parameter int GREEN_CYC  = 5,
  parameter int AMBER_CYC  = 2,
  parameter int ALLRED_CYC = 1,
  parameter int WALK_CYC   = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ped_req,
  input  logic       emerg,
  output logic [2:0] ns_light,
  output logic [2:0] ew_light,
  output logic       walk,
  output logic       ped_ack,
  output logic [2:0] phase
);

  if (GREEN_CYC < 1 || GREEN_CYC > 255 || AMBER_CYC < 1 || AMBER_CYC > 255 ||
      ALLRED_CYC < 1 || ALLRED_CYC > 255 || WALK_CYC < 1 || WALK_CYC > 255) begin : gBadParam
    $error("intersection_controller: every phase length must be in 1..255");
  end

  localparam int MAX_GA  = (GREEN_CYC > AMBER_CYC) ? GREEN_CYC : AMBER_CYC;
  localparam int MAX_RW  = (ALLRED_CYC > WALK_CYC) ? ALLRED_CYC : WALK_CYC;
  localparam int MAX_CYC = (MAX_GA > MAX_RW) ? MAX_GA : MAX_RW;
  localparam int TW      = (MAX_CYC < 1) ? 1 : $clog2(MAX_CYC + 1);

  ctrlState state;
  ctrlState nextState;
  ctrlState walkReturn;
  logic     pending;
  logic     timerLoad;
  logic [TW-1:0] timerLoadValue;
  logic [TW-1:0] unusedTimerValue;
  logic     timerZero;

  function automatic logic [TW-1:0] loadFor(input ctrlState s);
    case (s)
      NS_GREEN, EW_GREEN: loadFor = TW'(GREEN_CYC - 1);
      NS_AMBER, EW_AMBER: loadFor = TW'(AMBER_CYC - 1);
      ALLRED_A, ALLRED_B: loadFor = TW'(ALLRED_CYC - 1);
      PED_WALK:           loadFor = TW'(WALK_CYC - 1);
      default:            loadFor = '0;
    endcase
  endfunction

  phase_timer #(
    .WIDTH    (TW),
    .RESET_VAL(TW'(ALLRED_CYC - 1))
  ) timer (
    .clock    (clock),
    .reset    (reset),
    .load     (timerLoad),
    .loadValue(timerLoadValue),
    .value    (unusedTimerValue),
    .zero     (timerZero)
  );

  // Emergency pre-empts green immediately, lets amber run out, and cuts all-red/walk short.
  always_comb begin
    nextState = state;
    case (state)
      NS_GREEN: if (emerg || timerZero) nextState = NS_AMBER;
      NS_AMBER: if (timerZero) nextState = emerg ? EMERG_HOLD : ALLRED_A;
      ALLRED_A: begin
        if (emerg)          nextState = EMERG_HOLD;
        else if (timerZero) nextState = pending ? PED_WALK : EW_GREEN;
      end
      EW_GREEN: if (emerg || timerZero) nextState = EW_AMBER;
      EW_AMBER: if (timerZero) nextState = emerg ? EMERG_HOLD : ALLRED_B;
      ALLRED_B: begin
        if (emerg)          nextState = EMERG_HOLD;
        else if (timerZero) nextState = pending ? PED_WALK : NS_GREEN;
      end
      PED_WALK: begin
        if (emerg)          nextState = EMERG_HOLD;
        else if (timerZero) nextState = walkReturn;
      end
      EMERG_HOLD: if (!emerg) nextState = ALLRED_B;
      default:  nextState = ALLRED_B;
    endcase
  end

  assign timerLoad      = (nextState != state);
  assign timerLoadValue = loadFor(nextState);

  // Lamps and ack are registered from nextState so they line up with the state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= ALLRED_B;
      walkReturn <= NS_GREEN;
      pending    <= 1'b0;
      ns_light   <= RED;
      ew_light   <= RED;
      walk       <= 1'b0;
      ped_ack    <= 1'b0;
    end else begin
      state   <= nextState;
      pending <= ped_req | (pending & ~ped_ack);
      if (nextState == PED_WALK && state != PED_WALK)
        walkReturn <= (state == ALLRED_A) ? EW_GREEN : NS_GREEN;
      ns_light <= nsLamp(nextState);
      ew_light <= ewLamp(nextState);
      walk     <= (nextState == PED_WALK);
      ped_ack  <= (nextState == PED_WALK) && (state != PED_WALK);
    end
  end

  assign phase = state;

endmodule

// File: tb/tb_intersection_controller.sv
// Self-checking bench: constant vector tables, hand-written corner sequences and a randomized run against a phase model.
module tb_intersection_controller;
  import traffic_pkg::*;

  localparam int G = 5;
  localparam int A = 2;
  localparam int R = 1;
  localparam int W = 4;

  localparam logic [2:0] L_RED   = 3'b101;
  localparam logic [2:0] L_GREEN = 3'b110;
  localparam logic [2:0] L_AMBER = 3'b011;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       ped_req = 1'b0;
  logic       emerg = 1'b0;
  logic [2:0] ns_light, ew_light, phase;
  logic       walk, ped_ack;

  int checks = 0;
  int fails  = 0;

  intersection_controller #(
    .GREEN_CYC (G),
    .AMBER_CYC (A),
    .ALLRED_CYC(R),
    .WALK_CYC  (W)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .ped_req (ped_req),
    .emerg   (emerg),
    .ns_light(ns_light),
    .ew_light(ew_light),
    .walk    (walk),
    .ped_ack (ped_ack),
    .phase   (phase)
  );

  always #5 clock = ~clock;

  // Reference model: state name, cycles left in the phase, pending request, ack this cycle.
  ctrlState mSt, mAfter;
  int       mLeft;
  bit       mPend, mAck;
  bit       reqSince;

  function automatic int durOf(input ctrlState s);
    case (s)
      NS_GREEN, EW_GREEN: return G;
      NS_AMBER, EW_AMBER: return A;
      ALLRED_A, ALLRED_B: return R;
      PED_WALK:           return W;
      default:            return 1;
    endcase
  endfunction

  function automatic logic [2:0] expNs(input ctrlState s);
    if (s == NS_GREEN) return L_GREEN;
    if (s == NS_AMBER) return L_AMBER;
    return L_RED;
  endfunction

  function automatic logic [2:0] expEw(input ctrlState s);
    if (s == EW_GREEN) return L_GREEN;
    if (s == EW_AMBER) return L_AMBER;
    return L_RED;
  endfunction

  task automatic modelReset();
    mSt = ALLRED_B; mAfter = NS_GREEN; mLeft = R; mPend = 0; mAck = 0;
  endtask

  task automatic modelStep(input bit p, input bit e);
    ctrlState nx;
    bit done;
    nx = mSt;
    done = (mLeft == 1);
    case (mSt)
      NS_GREEN: if (e || done) nx = NS_AMBER;
      NS_AMBER: if (done) nx = e ? EMERG_HOLD : ALLRED_A;
      ALLRED_A: if (e) nx = EMERG_HOLD;
                else if (done) begin nx = mPend ? PED_WALK : EW_GREEN; mAfter = EW_GREEN; end
      EW_GREEN: if (e || done) nx = EW_AMBER;
      EW_AMBER: if (done) nx = e ? EMERG_HOLD : ALLRED_B;
      ALLRED_B: if (e) nx = EMERG_HOLD;
                else if (done) begin nx = mPend ? PED_WALK : NS_GREEN; mAfter = NS_GREEN; end
      PED_WALK: if (e) nx = EMERG_HOLD; else if (done) nx = mAfter;
      default:  if (!e) nx = ALLRED_B;
    endcase
    mPend = p | (mPend & !mAck);
    mAck  = (nx == PED_WALK) && (mSt != PED_WALK);
    if (nx != mSt) mLeft = durOf(nx);
    else if (mSt != EMERG_HOLD) mLeft--;
    mSt = nx;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input bit p, input bit e);
    ped_req = p;
    emerg   = e;
    @(posedge clock);
    #1;
    modelStep(p, e);
  endtask

  task automatic doReset();
    ped_req = 0;
    emerg   = 0;
    reset   = 0;
    @(posedge clock);
    #1;
    reset = 1;
    modelReset();
    reqSince = 0;
  endtask

  typedef struct {
    bit         rst;
    bit         ped;
    bit         em;
    logic [2:0] ns;
    logic [2:0] ew;
    bit         walk;
    bit         ack;
  } vecT;

  vecT vecs[$];

  function automatic void addVec(bit rst, bit ped, bit em, logic [2:0] ns, logic [2:0] ew, bit wk, bit ack);
    vecs.push_back('{rst, ped, em, ns, ew, wk, ack});
  endfunction

  initial begin
    int ackCount;
    bit emCur;
    bit p;

    // Row k: inputs during cycle k after reset, outputs expected in cycle k+1.
    for (int k = 0; k < 17; k++) begin
      if (k < 5)       addVec(k == 0, 0, 0, L_GREEN, L_RED, 0, 0);
      else if (k < 7)  addVec(0, 0, 0, L_AMBER, L_RED, 0, 0);
      else if (k == 7) addVec(0, 0, 0, L_RED, L_RED, 0, 0);
      else if (k < 13) addVec(0, 0, 0, L_RED, L_GREEN, 0, 0);
      else if (k < 15) addVec(0, 0, 0, L_RED, L_AMBER, 0, 0);
      else if (k == 15) addVec(0, 0, 0, L_RED, L_RED, 0, 0);
      else             addVec(0, 0, 0, L_GREEN, L_RED, 0, 0);
    end
    for (int k = 0; k < 21; k++) begin
      if (k < 5)       addVec(k == 0, k == 1, 0, L_GREEN, L_RED, 0, 0);
      else if (k < 7)  addVec(0, 0, 0, L_AMBER, L_RED, 0, 0);
      else if (k == 7) addVec(0, 0, 0, L_RED, L_RED, 0, 0);
      else if (k == 8) addVec(0, 0, 0, L_RED, L_RED, 1, 1);
      else if (k < 12) addVec(0, 0, 0, L_RED, L_RED, 1, 0);
      else if (k < 17) addVec(0, 0, 0, L_RED, L_GREEN, 0, 0);
      else if (k < 19) addVec(0, 0, 0, L_RED, L_AMBER, 0, 0);
      else if (k == 19) addVec(0, 0, 0, L_RED, L_RED, 0, 0);
      else             addVec(0, 0, 0, L_GREEN, L_RED, 0, 0);
    end

    #1 reset = 0;
    #3;
    chk("rst.ns", int'(ns_light), int'(L_RED));
    chk("rst.ew", int'(ew_light), int'(L_RED));
    chk("rst.walk", int'(walk), 0);
    chk("rst.ack", int'(ped_ack), 0);
    chk("rst.phase", int'(phase), int'(ALLRED_B));

    foreach (vecs[i]) begin
      if (vecs[i].rst) doReset();
      step(vecs[i].ped, vecs[i].em);
      chk($sformatf("vec%0d.ns", i), int'(ns_light), int'(vecs[i].ns));
      chk($sformatf("vec%0d.ew", i), int'(ew_light), int'(vecs[i].ew));
      chk($sformatf("vec%0d.walk", i), int'(walk), int'(vecs[i].walk));
      chk($sformatf("vec%0d.ack", i), int'(ped_ack), int'(vecs[i].ack));
    end

    // Emergency raised in the second NS green cycle.
    doReset();
    step(0, 0); step(0, 0);
    step(0, 1);
    chk("em.amber1", int'(ns_light), int'(L_AMBER));
    step(0, 1);
    chk("em.amber2", int'(ns_light), int'(L_AMBER));
    step(0, 1);
    chk("em.hold.phase", int'(phase), int'(EMERG_HOLD));
    chk("em.hold.ns", int'(ns_light), int'(L_RED));
    chk("em.hold.ew", int'(ew_light), int'(L_RED));
    step(0, 1); step(0, 1); step(0, 1);
    chk("em.held", int'(phase), int'(EMERG_HOLD));
    step(0, 0);
    chk("em.clear.phase", int'(phase), int'(ALLRED_B));
    chk("em.clear.ns", int'(ns_light), int'(L_RED));
    step(0, 0);
    chk("em.resume", int'(ns_light), int'(L_GREEN));

    // Emergency in the second walk cycle.
    doReset();
    step(1, 0);
    for (int i = 0; i < 7; i++) step(0, 0);
    step(0, 0);
    chk("ew.walk1", int'(walk), 1);
    chk("ew.ack1", int'(ped_ack), 1);
    ackCount = 0;
    step(0, 0);
    ackCount += int'(ped_ack);
    chk("ew.walk2", int'(walk), 1);
    step(0, 1);
    ackCount += int'(ped_ack);
    chk("ew.hold", int'(phase), int'(EMERG_HOLD));
    chk("ew.walkoff", int'(walk), 0);
    step(0, 1); ackCount += int'(ped_ack);
    step(0, 0); ackCount += int'(ped_ack);
    chk("ew.allred", int'(phase), int'(ALLRED_B));
    step(0, 0); ackCount += int'(ped_ack);
    chk("ew.nsgreen", int'(ns_light), int'(L_GREEN));
    chk("ew.noreack", ackCount, 0);

    // Asynchronous reset in EW green with a request pending.
    doReset();
    for (int i = 0; i < 9; i++) step(0, 0);
    step(1, 0);
    chk("ar.ewgreen", int'(ew_light), int'(L_GREEN));
    #2 reset = 0;
    #1;
    chk("ar.ns", int'(ns_light), int'(L_RED));
    chk("ar.ew", int'(ew_light), int'(L_RED));
    chk("ar.walk", int'(walk), 0);
    chk("ar.phase", int'(phase), int'(ALLRED_B));
    @(posedge clock);
    #1;
    reset = 1;
    modelReset();
    step(0, 0);
    chk("ar.restart", int'(ns_light), int'(L_GREEN));
    for (int i = 0; i < 7; i++) step(0, 0);
    step(0, 0);
    chk("ar.nopend.ew", int'(ew_light), int'(L_GREEN));
    chk("ar.nopend.walk", int'(walk), 0);

    // Randomized run against the model plus safety invariants.
    doReset();
    emCur = 0;
    for (int c = 0; c < 10000; c++) begin
      if ($urandom_range(0, 29) == 0) emCur = ~emCur;
      p = ($urandom_range(0, 5) == 0);
      step(p, emCur);
      reqSince = reqSince | p;
      chk("rnd.phase", int'(phase), int'(mSt));
      chk("rnd.ns", int'(ns_light), int'(expNs(mSt)));
      chk("rnd.ew", int'(ew_light), int'(expEw(mSt)));
      chk("rnd.walk", int'(walk), int'(mSt == PED_WALK));
      chk("rnd.ack", int'(ped_ack), int'(mAck));
      chk("rnd.conflict", int'(ns_light != L_RED && ew_light != L_RED), 0);
      if (ped_ack) begin
        chk("rnd.ackcause", int'(reqSince), 1);
        reqSince = 0;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/intersection_controller.md
INTERSECTION_CONTROLLER -- requirements
Module: intersection_controller

Interface
REQ-001 SHALL have parameter GREEN_CYC, default 5, cycles per green phase.
REQ-002 SHALL have parameter AMBER_CYC, default 2, cycles per amber phase.
REQ-003 SHALL have parameter ALLRED_CYC, default 1, cycles per all-red clearance.
REQ-004 SHALL have parameter WALK_CYC, default 4, cycles per pedestrian walk phase.
REQ-005 SHALL have port clock  input  1  clock; all state updates on its rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port ped_req  input  1  pedestrian request; any cycle high sets a pending flag.
REQ-008 SHALL have port emerg  input  1  emergency override, level-sensitive.
REQ-009 SHALL have port ns_light  output  3  north-south lamp code.
REQ-010 SHALL have port ew_light  output  3  east-west lamp code.
REQ-011 SHALL have port walk  output  1  pedestrian walk lamp.
REQ-012 SHALL have port ped_ack  output  1  one-cycle pulse when a pending request is served.
REQ-013 SHALL have port phase  output  3  current state encoding, for debug.

Function
REQ-014 SHALL use lamp codes RED=3'b101, GREEN=3'b110, AMBER=3'b011; no other value ever driven.
REQ-015 SHALL implement states NS_GREEN, NS_AMBER, ALLRED_A, EW_GREEN, EW_AMBER, ALLRED_B, PED_WALK, EMERG_HOLD.
REQ-016 SHALL keep each timed state for exactly its parameter count of cycles: timer loaded with N-1 on entry, decremented each cycle, transition on the cycle it reads 0.
REQ-017 SHALL sequence NS_GREEN -> NS_AMBER -> ALLRED_A -> EW_GREEN -> EW_AMBER -> ALLRED_B -> NS_GREEN when no request or emergency is active.
REQ-018 SHALL, on leaving ALLRED_A or ALLRED_B with pending set and emerg low, enter PED_WALK instead of the next green; after PED_WALK, continue to the green that would have followed.
REQ-019 SHALL pulse ped_ack for exactly the first cycle of PED_WALK and clear pending on that same edge; a ped_req high in that cycle re-sets pending.
REQ-020 SHALL drive walk=1 only in PED_WALK; both lamps RED in PED_WALK, ALLRED_A, ALLRED_B, EMERG_HOLD.
REQ-021 SHALL never drive a non-RED code on both ns_light and ew_light in the same cycle.
REQ-022 SHALL, when emerg is high in NS_GREEN or EW_GREEN, move next cycle to the matching amber with a full AMBER_CYC count.
REQ-023 SHALL, when emerg is high in an amber state, complete the amber count and then enter EMERG_HOLD.
REQ-024 SHALL, when emerg is high in ALLRED_A, ALLRED_B or PED_WALK, enter EMERG_HOLD next cycle; an interrupted walk does not pulse ped_ack again and pending is not restored.
REQ-025 SHALL hold EMERG_HOLD while emerg is high; on the cycle after emerg reads low, enter ALLRED_B (so NS_GREEN follows).
REQ-026 SHALL decode all outputs except ped_ack from the registered state only; no combinational input-to-output path.
REQ-027 SHALL size the timer to ceil(log2(max parameter+1)) bits; each parameter is 1 to 255; values below 1 are a compile-time error.

Reset
REQ-028 SHALL, on reset low, immediately force state ALLRED_B, timer ALLRED_CYC-1, pending 0, ns_light=ew_light=RED, walk 0, ped_ack 0.
REQ-029 SHALL, on reset asserted mid-phase (including PED_WALK or EMERG_HOLD), abandon that phase with no ack or request carried over.
REQ-030 SHALL, on first rising edge after reset release, start the ALLRED_B count and reach NS_GREEN after ALLRED_CYC cycles.

Structure
REQ-031 SHALL place lamp code constants and the state enumeration in shared package traffic_pkg.
REQ-032 SHALL implement the loadable down-counter as sub-module phase_timer (load, value, zero flag).

Verification (defaults GREEN=5, AMBER=2, ALLRED=1, WALK=4)
REQ-033 Release reset, no inputs -> ns GREEN cycles 1-5, AMBER 6-7, all-red 8, ew GREEN 9-13; full period 16 cycles.
REQ-034 ped_req pulse during NS_GREEN -> after ALLRED_A, 4 cycles walk=1 with both RED, ped_ack one cycle at walk start, then EW_GREEN.
REQ-035 emerg high at NS_GREEN cycle 2 -> NS_AMBER 2 cycles, EMERG_HOLD all-red while high; release -> 1 cycle all-red then NS_GREEN.
REQ-036 emerg high during PED_WALK cycle 2 -> EMERG_HOLD next cycle, walk=0, no second ped_ack.
REQ-037 reset pulse during EW_GREEN -> lamps RED same cycle without clock, pending 0, restart as REQ-033.
REQ-038 Random ped_req/emerg for 10000 cycles -> never both lamps non-RED; each ped_ack preceded by a ped_req since the previous ack.
